spi_xip_ctrl: RTL
=================

Name: spi_xip_ctrl

Overview:
APB slave that maps a memory window onto a serial NOR flash: each 32-bit APB read in the window runs a complete SPI read transaction (command, address, data), with no intermediate SPI core. Successor to the fixed-divider flash bridge in the peripheral subsystem. Adds the following:
- parametrised flash address width and chip-select count;
- a runtime clock divider and chip-select mask;
- an error flag and a transfer counter;
- an optional fast-read mode.

Sits behind the APB decoder in the ysyxSoC peripheral tree.

Parameters:
ADDR_START, 32'h30000000, first byte address of the flash window
ADDR_END, 32'h3fffffff, last byte address of the flash window
CS_NUM, 2, number of chip-select outputs (1..8)
FADDR_BYTES, 3, flash address bytes sent (3 or 4)
DIV_W, 8, width of the clock divider field

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
paddr  in  32  APB address
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
pwdata  in  32  APB write data
pstrb  in  4  APB byte strobes (CSR writes only; partial strobes write the selected bytes)
pready  out  1  APB ready
prdata  out  32  APB read data
pslverr  out  1  APB error
spi_sck  out  1  SPI clock (mode 0, idle low)
spi_cs_n  out  CS_NUM  active-low chip selects
spi_mosi  out  1  serial out
spi_miso  in  1  serial in

Behaviour:
- Reset values:
  - spi_sck=0, spi_cs_n=all 1, spi_mosi=1, pready=0, prdata=0, pslverr=0.
  - CTRL.div=0, CTRL.csmask=1 (CS0 only), STATUS.err=0, XCNT=0.
- Address decode: in_window = ADDR_START<=paddr<=ADDR_END; otherwise CSR space, paddr[3:0] offset.
- CSR map:
  - 0x0 CTRL: [DIV_W-1:0] div; [CS_NUM+15:16] csmask.
  - 0x4 STATUS: bit0 err, sticky, write-1-to-clear.
  - 0x8 XCNT: count of completed flash reads, read-only, wraps 2^32-1 -> 0.
  - Other offsets read 0, writes ignored, pslverr=0.
- CSR access: zero wait state; pready=1 in the first cycle of psel&&penable.
- Flash-window write: zero wait state; pready=1 and pslverr=1; err<=1; no SPI activity.
- Flash-window read FSM, states IDLE, CMD, ADDR, DUMMY, DATA, DONE:
  - IDLE -> CMD on psel&&penable&&!pwrite&&in_window. Latch the address (byte address low 2 bits forced 0), div and csmask.
  - In CMD, cs_n for the csmask bits goes low.
  - CMD: 8 bits of 8'h03. ADDR: FADDR_BYTES*8 bits of paddr[FADDR_BYTES*8-1:0], MSB first.
  - DUMMY is skipped. DATA: 32 bits. Then DONE.
  - DONE, one cycle: cs_n all 1, pready=1, prdata = assembled word, XCNT+1. Then IDLE.
- Bit timing:
  - Half-period = div+1 clk cycles.
  - MOSI is updated when sck falls (the first bit is valid when CS asserts). MISO is sampled in the cycle sck rises.
  - CS is low for exactly (8+8*FADDR_BYTES+32)*2*(div+1) cycles. With defaults and div=0: 128 cycles; pready in cycle 130 after the accepting edge.
- Byte order: the first flash byte received goes to prdata[7:0], the fourth to [31:24] (little-endian word).
- prdata holds its value until the next completed read or CSR read. pready is 0 while the FSM is busy. psel/penable must stay high until pready (APB rule).
- Reset mid-transfer: cs_n rises and sck falls asynchronously; the FSM returns to IDLE; no pready is issued.
- A CTRL write cannot occur during a transfer (APB is serialized). Latched div/csmask are used for the whole transfer.
- csmask=0: the SPI sequence still runs with no CS asserted; prdata is whatever is sampled on MISO.

Optional Feature:
SPI_XIP_FASTREAD_EN:
- Defined: the command is 8'h0B and the DUMMY state inserts 8 sck cycles (MOSI=1, MISO ignored) between ADDR and DATA. CS-low time grows by 16*(div+1) cycles.
- Undefined: the command is 8'h03 and DUMMY is never entered.

Decomposition:
- Package spi_xip_pkg holds:
  - FSM state enum;
  - CSR offsets (CTRL 0x0, STATUS 0x4, XCNT 0x8);
  - command constants CMD_READ=8'h03, CMD_FREAD=8'h0B, DUMMY_CYCLES=8.
- One sub-module, spi_xip_sckgen: divider counter producing sck plus one-cycle rise/fall strobes, with enable and latched div.

Test Plan:
- Flash read of 0x30000104, div=0, flash model holds bytes 11 22 33 44 at 0x104 -> MOSI carries 03 00 01 04; pready in cycle 130; prdata=32'h44332211; XCNT=1.
- Write CTRL div=3, csmask=2'b10, then read 0x30000000 -> only spi_cs_n[1] low; sck half-period 4 clk; CS low for 512 cycles.
- Write to 0x30000010 -> pready=1, pslverr=1 same cycle; no CS activity; STATUS=1. Write STATUS=1 -> STATUS=0.
- Assert resetn=0 at data bit 10 -> cs_n=all 1 and sck=0 immediately; no pready; the next read completes normally with correct data.
- Preload XCNT to 32'hFFFFFFFF by performing reads in a forced-state test, then one read -> XCNT=0.
- With SPI_XIP_FASTREAD_EN defined: read 0x30000000 -> command 0B, 8 dummy sck cycles, CS low for 144 cycles at div=0, correct data.

Source files
------------

// File: rtl/spi_xip_pkg.sv
// Shared constants for the SPI execute-in-place flash bridge: FSM encodings,
// CSR offsets, flash command opcodes and a byte-order helper.
package spi_xip_pkg;

    typedef logic [2:0] xip_state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DUMMY = 3'd3;
    localparam logic [2:0] ST_DATA  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [3:0] CSR_CTRL   = 4'h0;
    localparam logic [3:0] CSR_STATUS = 4'h4;
    localparam logic [3:0] CSR_XCNT   = 4'h8;

    localparam logic [7:0] CMD_READ     = 8'h03;
    localparam logic [7:0] CMD_FREAD    = 8'h0B;
    localparam int         DUMMY_CYCLES = 8;

    // Bytes arrive first-byte-in-MSB; the bus wants the first byte in [7:0].
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_xip_sckgen.sv
// SPI mode-0 clock generator: half-period of div+1 clk cycles, with one-cycle
// strobes in the cycle whose closing edge raises or lowers sck.
module spi_xip_sckgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             sck,
    output logic             rise,
    output logic             fall
);

    logic [DIV_W-1:0] cnt;
    logic             expire;

    assign expire = en && (cnt == div);
    assign rise   = expire && !sck;
    assign fall   = expire && sck;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (expire) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_xip_ctrl.sv
// APB-mapped serial NOR flash window: each in-window read runs one full SPI read.
// Define SPI_XIP_FASTREAD_EN to use fast read (0x0B) with 8 dummy clocks.
module spi_xip_ctrl
    import spi_xip_pkg::*;
#(
    parameter logic [31:0] ADDR_START  = 32'h3000_0000,
    parameter logic [31:0] ADDR_END    = 32'h3fff_ffff,
    parameter int          CS_NUM      = 2,
    parameter int          FADDR_BYTES = 3,
    parameter int          DIV_W       = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pstrb,
    output logic              pready,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic              spi_sck,
    output logic [CS_NUM-1:0] spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int ADDR_BITS = 8 * FADDR_BYTES;
    localparam int TX_W      = 8 + ADDR_BITS;

`ifdef SPI_XIP_FASTREAD_EN
    localparam logic [7:0] READ_CMD   = CMD_FREAD;
    localparam logic [2:0] AFTER_ADDR = ST_DUMMY;
`else
    localparam logic [7:0] READ_CMD   = CMD_READ;
    localparam logic [2:0] AFTER_ADDR = ST_DATA;
`endif

    xip_state_t        state;
    xip_state_t        next_phase;
    logic              phase_last;
    logic [5:0]        bitcnt;
    logic [TX_W-1:0]   tx;
    logic [31:0]       rx;
    logic [DIV_W-1:0]  div_q;
    logic [CS_NUM-1:0] cs_n_q;

    logic [DIV_W-1:0]  ctrl_div;
    logic [CS_NUM-1:0] ctrl_csmask;
    logic              err;
    logic [31:0]       xcnt;
    logic [31:0]       ctrl_word;
    logic [31:0]       csr_rdata;

    logic              pready_q;
    logic              pslverr_q;
    logic [31:0]       prdata_q;

    logic              in_window;
    logic              setup;
    logic              access;
    logic              rd_start;
    logic              csr_resp;
    logic              busy;
    logic              sck_rise;
    logic              sck_fall;
    logic              unused_bits;

    assign in_window = (paddr >= ADDR_START) && (paddr <= ADDR_END);
    assign setup     = psel && !penable;
    assign access    = psel && penable;
    // pready_q blocks re-acceptance while the master still holds the finished access.
    assign rd_start  = (state == ST_IDLE) && access && !pwrite && in_window && !pready_q;
    assign csr_resp  = setup && !(in_window && !pwrite);
    assign busy      = (state == ST_CMD) || (state == ST_ADDR) ||
                       (state == ST_DUMMY) || (state == ST_DATA);

    assign pready      = pready_q;
    assign pslverr     = pslverr_q;
    assign prdata      = prdata_q;
    assign spi_cs_n    = cs_n_q;
    assign spi_mosi    = tx[TX_W-1];
    assign unused_bits = ^{pwdata, pstrb};

    spi_xip_sckgen #(
        .DIV_W (DIV_W)
    ) u_sckgen (
        .clk    (clk),
        .resetn (resetn),
        .en     (busy),
        .div    (div_q),
        .sck    (spi_sck),
        .rise   (sck_rise),
        .fall   (sck_fall)
    );

    always_comb begin
        next_phase = ST_IDLE;
        phase_last = 1'b0;
        case (state)
            ST_CMD: begin
                phase_last = (bitcnt == 6'd7);
                next_phase = ST_ADDR;
            end
            ST_ADDR: begin
                phase_last = (bitcnt == 6'(ADDR_BITS - 1));
                next_phase = AFTER_ADDR;
            end
            ST_DUMMY: begin
                phase_last = (bitcnt == 6'(DUMMY_CYCLES - 1));
                next_phase = ST_DATA;
            end
            ST_DATA: begin
                phase_last = (bitcnt == 6'd31);
                next_phase = ST_DONE;
            end
            default: ;
        endcase
    end

    // Transfer FSM; MOSI shifts on sck fall with 1s filling dummy and data phases.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            bitcnt <= '0;
            tx     <= '1;
            div_q  <= '0;
            cs_n_q <= '1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_start) begin
                        state  <= ST_CMD;
                        bitcnt <= '0;
                        div_q  <= ctrl_div;
                        cs_n_q <= ~ctrl_csmask;
                        tx     <= {READ_CMD, paddr[ADDR_BITS-1:2], 2'b00};
                    end
                end
                ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                    if (sck_fall) begin
                        tx <= {tx[TX_W-2:0], 1'b1};
                        if (phase_last) begin
                            bitcnt <= '0;
                            state  <= next_phase;
                            if (state == ST_DATA)
                                cs_n_q <= '1;
                        end else begin
                            bitcnt <= bitcnt + 6'd1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ST_DATA) && sck_rise)
            rx <= {rx[30:0], spi_miso};
    end

    always_comb begin
        ctrl_word = '0;
        ctrl_word[DIV_W-1:0]    = ctrl_div;
        ctrl_word[16 +: CS_NUM] = ctrl_csmask;
    end

    always_comb begin
        csr_rdata = '0;
        case (paddr[3:0])
            CSR_CTRL:   csr_rdata    = ctrl_word;
            CSR_STATUS: csr_rdata[0] = err;
            CSR_XCNT:   csr_rdata    = xcnt;
            default:    ;
        endcase
    end

    // APB response registered at the setup edge so CSR accesses see pready immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= '0;
            ctrl_div    <= '0;
            ctrl_csmask <= CS_NUM'(1);
            err         <= 1'b0;
            xcnt        <= '0;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            if (csr_resp) begin
                pready_q <= 1'b1;
                if (in_window)
                    pslverr_q <= 1'b1;
                else if (!pwrite)
                    prdata_q <= csr_rdata;
            end
            if (state == ST_DONE) begin
                pready_q <= 1'b1;
                prdata_q <= bswap32(rx);
                xcnt     <= xcnt + 32'd1;
            end
            if (access && pready_q && pwrite) begin
                if (in_window) begin
                    err <= 1'b1;
                end else begin
                    case (paddr[3:0])
                        CSR_CTRL: begin
                            for (int i = 0; i < DIV_W; i++)
                                if (pstrb[i / 8]) ctrl_div[i] <= pwdata[i];
                            for (int i = 0; i < CS_NUM; i++)
                                if (pstrb[2]) ctrl_csmask[i] <= pwdata[16 + i];
                        end
                        CSR_STATUS: if (pstrb[0] && pwdata[0]) err <= 1'b0;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
